// File: rtl/kv_cache_refill_ctrl.sv
// kv_cache_refill_ctrl: miss handler for the set-associative cache.
// Picks a victim way, writes it back if dirty, refills the line, then touches the LRU.
module kv_cache_refill_ctrl #(
  parameter  int WAY_NUM     = 4,
  parameter  int LINE_NUM    = 64,
  parameter  int LINE_WORDS  = 4,
  parameter  int DATA_WIDTH  = 32,
  parameter  int ADDR_WIDTH  = 32,
  localparam int INDEX_WIDTH = $clog2(LINE_NUM / WAY_NUM),
  localparam int OFS_WIDTH   = $clog2(LINE_WORDS * DATA_WIDTH / 8),
  localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - OFS_WIDTH,
  localparam int WORD_WIDTH  = $clog2(LINE_WORDS)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_miss_valid,
  output logic                           o_miss_ready,
  input  logic [ADDR_WIDTH-1:0]          i_miss_addr,
  output logic [INDEX_WIDTH-1:0]         o_index,
  input  logic [WAY_NUM-1:0]             i_killmask,
  input  logic [WAY_NUM-1:0]             i_way_valid,
  input  logic [WAY_NUM-1:0]             i_way_dirty,
  input  logic [WAY_NUM*TAG_WIDTH-1:0]   i_way_tag,
  output logic                           o_rd_en,
  output logic [WAY_NUM-1:0]             o_rd_way,
  output logic [WORD_WIDTH-1:0]          o_rd_word,
  input  logic [DATA_WIDTH-1:0]          i_rd_data,
  output logic                           o_mem_wvalid,
  input  logic                           i_mem_wready,
  output logic [ADDR_WIDTH-1:0]          o_mem_waddr,
  output logic [DATA_WIDTH-1:0]          o_mem_wdata,
  output logic                           o_mem_wlast,
  output logic                           o_mem_arvalid,
  input  logic                           i_mem_arready,
  output logic [ADDR_WIDTH-1:0]          o_mem_araddr,
  input  logic                           i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]          i_mem_rdata,
  input  logic                           i_mem_rlast,
  output logic                           o_fill_we,
  output logic [WAY_NUM-1:0]             o_fill_way,
  output logic [WORD_WIDTH-1:0]          o_fill_word,
  output logic [DATA_WIDTH-1:0]          o_fill_data,
  output logic                           o_tag_we,
  output logic [WAY_NUM-1:0]             o_tag_way,
  output logic [TAG_WIDTH-1:0]           o_tag,
  output logic                           o_lru_update,
  output logic [WAY_NUM-1:0]             o_lru_hitway,
  output logic                           o_done,
  output logic                           o_err
);

  localparam int WAY_BITS  = $clog2(WAY_NUM);
  localparam int BYTE_BITS = OFS_WIDTH - WORD_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_WB_RD, S_WB_WR, S_AR, S_FILL, S_COMMIT
  } state_t;

  state_t                  r_state;
  state_t                  w_nextState;
  logic [ADDR_WIDTH-1:0]   r_missAddr;
  logic [WAY_NUM-1:0]      r_victim;
  logic [TAG_WIDTH-1:0]    r_victimTag;
  logic [WORD_WIDTH-1:0]   r_wordCnt;
  logic [DATA_WIDTH-1:0]   r_wdataHold;
  logic                    r_rdPending;
  logic                    r_err;

  logic [WAY_BITS-1:0]     w_victimIdx;
  logic                    w_victimDirty;
  logic                    w_lastWord;
  logic [TAG_WIDTH-1:0]    w_missTag;
  logic [OFS_WIDTH-1:0]    w_wordOfs;

  assign o_index    = r_missAddr[OFS_WIDTH +: INDEX_WIDTH];
  assign w_missTag  = r_missAddr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign w_lastWord = (r_wordCnt == WORD_WIDTH'(LINE_WORDS - 1));
  assign w_wordOfs  = OFS_WIDTH'(r_wordCnt) << BYTE_BITS;
  assign o_err      = r_err;

  // Invalid ways are always preferred over the LRU choice; an empty killmask falls back to the top way.
  always_comb begin
    w_victimIdx = WAY_BITS'(WAY_NUM - 1);
    if (!(&i_way_valid)) begin
      for (int i = WAY_NUM - 1; i >= 0; i--)
        if (!i_way_valid[i]) w_victimIdx = WAY_BITS'(i);
    end else begin
      for (int i = WAY_NUM - 1; i >= 0; i--)
        if (i_killmask[i]) w_victimIdx = WAY_BITS'(i);
    end
    w_victimDirty = i_way_valid[w_victimIdx] & i_way_dirty[w_victimIdx];
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (i_miss_valid) w_nextState = S_SELECT;
      S_SELECT: w_nextState = w_victimDirty ? S_WB_RD : S_AR;
      S_WB_RD:  w_nextState = S_WB_WR;
      S_WB_WR:  if (i_mem_wready) w_nextState = w_lastWord ? S_AR : S_WB_RD;
      S_AR:     if (i_mem_arready) w_nextState = S_FILL;
      S_FILL:   if (i_mem_rvalid && w_lastWord) w_nextState = S_COMMIT;
      S_COMMIT: w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    o_miss_ready  = 1'b0;
    o_rd_en       = 1'b0;
    o_rd_way      = '0;
    o_rd_word     = '0;
    o_mem_wvalid  = 1'b0;
    o_mem_waddr   = '0;
    o_mem_wdata   = '0;
    o_mem_wlast   = 1'b0;
    o_mem_arvalid = 1'b0;
    o_mem_araddr  = '0;
    o_fill_we     = 1'b0;
    o_fill_way    = '0;
    o_fill_word   = '0;
    o_fill_data   = '0;
    o_tag_we      = 1'b0;
    o_tag_way     = '0;
    o_tag         = '0;
    o_lru_update  = 1'b0;
    o_lru_hitway  = '0;
    o_done        = 1'b0;
    case (r_state)
      S_IDLE: o_miss_ready = 1'b1;
      S_WB_RD: begin
        o_rd_en   = 1'b1;
        o_rd_way  = r_victim;
        o_rd_word = r_wordCnt;
      end
      // Array data is only present in the first WB_WR cycle; later cycles replay the hold copy.
      S_WB_WR: begin
        o_mem_wvalid = 1'b1;
        o_mem_waddr  = {r_victimTag, o_index, w_wordOfs};
        o_mem_wdata  = r_rdPending ? i_rd_data : r_wdataHold;
        o_mem_wlast  = w_lastWord;
      end
      S_AR: begin
        o_mem_arvalid = 1'b1;
        o_mem_araddr  = {r_missAddr[ADDR_WIDTH-1:OFS_WIDTH], {OFS_WIDTH{1'b0}}};
      end
      S_FILL: begin
        if (i_mem_rvalid) begin
          o_fill_we   = 1'b1;
          o_fill_way  = r_victim;
          o_fill_word = r_wordCnt;
          o_fill_data = i_mem_rdata;
        end
      end
      S_COMMIT: begin
        o_tag_we     = 1'b1;
        o_tag_way    = r_victim;
        o_tag        = w_missTag;
        o_lru_update = 1'b1;
        o_lru_hitway = r_victim;
        o_done       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_missAddr  <= '0;
      r_victim    <= '0;
      r_victimTag <= '0;
      r_wordCnt   <= '0;
      r_wdataHold <= '0;
      r_rdPending <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_rdPending <= (r_state == S_WB_RD);
      case (r_state)
        S_IDLE: begin
          if (i_miss_valid) begin
            r_missAddr <= i_miss_addr;
            r_wordCnt  <= '0;
          end
        end
        S_SELECT: begin
          r_victim    <= WAY_NUM'(1) << w_victimIdx;
          r_victimTag <= i_way_tag[w_victimIdx*TAG_WIDTH +: TAG_WIDTH];
        end
        S_WB_WR: begin
          if (r_rdPending) r_wdataHold <= i_rd_data;
          if (i_mem_wready) r_wordCnt <= w_lastWord ? '0 : r_wordCnt + 1'b1;
        end
        // The beat counter alone ends the fill; rlast is only cross-checked.
        S_FILL: begin
          if (i_mem_rvalid) begin
            r_wordCnt <= r_wordCnt + 1'b1;
            if (i_mem_rlast != w_lastWord) r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/kv_cache_refill_ctrl.md
Name: kv_cache_refill_ctrl

Overview:
Miss-handling controller for the set-associative cache. It consumes the LRU victim one-hot mask and picks the victim way. It writes back the victim line to memory if it is dirty, then fetches the missing line and fills the data/tag arrays. Finally it feeds the filled way back to the LRU tracker as a hit, closing the replacement loop between the cache pipeline and the memory bus.

Parameters:
WAY_NUM, 4, number of ways; power of two, 2 or more
LINE_NUM, 64, total lines; INDEX_WIDTH = clog2(LINE_NUM/WAY_NUM)
LINE_WORDS, 4, data words per line; power of two, 2 or more
DATA_WIDTH, 32, word width
ADDR_WIDTH, 32, byte address width; OFS_WIDTH = clog2(LINE_WORDS*DATA_WIDTH/8); TAG_WIDTH = ADDR_WIDTH-INDEX_WIDTH-OFS_WIDTH

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_miss_valid / o_miss_ready  in/out  1  miss request handshake
i_miss_addr  in  ADDR_WIDTH  missing byte address
o_index  out  INDEX_WIDTH  set index to LRU and tag arrays (held for whole miss)
i_killmask  in  WAY_NUM  LRU victim mask for o_index
i_way_valid, i_way_dirty  in  WAY_NUM  per-way status of set o_index
i_way_tag  in  WAY_NUM*TAG_WIDTH  per-way tags, way0 in LSBs
o_rd_en  out  1  array read request; o_rd_way (WAY_NUM one-hot), o_rd_word (clog2 LINE_WORDS)
i_rd_data  in  DATA_WIDTH  array read data, valid exactly 1 cycle after o_rd_en
o_mem_wvalid / i_mem_wready  out/in  1  writeback beat handshake; o_mem_waddr ADDR_WIDTH, o_mem_wdata DATA_WIDTH, o_mem_wlast 1
o_mem_arvalid / i_mem_arready  out/in  1  line read request; o_mem_araddr ADDR_WIDTH (line aligned)
i_mem_rvalid, i_mem_rdata, i_mem_rlast  in  1/DATA_WIDTH/1  read beats (no backpressure)
o_fill_we, o_fill_way (one-hot), o_fill_word, o_fill_data  out  array data write
o_tag_we, o_tag_way (one-hot), o_tag  out  tag write; sets valid, clears dirty
o_lru_update, o_lru_hitway (WAY_NUM one-hot)  out  LRU touch of filled way
o_done  out  1  one-cycle pulse at completion
o_err  out  1  sticky protocol error flag

Behaviour:
- Reset: state IDLE, counters 0, o_miss_ready=1, all valid/enable/pulse outputs 0, o_err=0; data/address outputs 0.
- IDLE: o_miss_ready=1. On i_miss_valid, latch addr, go SELECT. o_miss_ready=0 in every other state.
- SELECT (1 cycle): if any i_way_valid bit is 0, victim = lowest invalid way. Otherwise victim = lowest set bit of i_killmask; if i_killmask is 0, victim = way WAY_NUM-1. Next state is WB_RD if victim is valid and dirty, else AR.
- WB_RD: o_rd_en=1 for word k; go WB_WR.
- WB_WR: capture i_rd_data into a hold register; o_mem_wvalid=1 and held until i_mem_wready. waddr = {victim tag, index, k*DATA_WIDTH/8}; wlast=1 when k=LINE_WORDS-1. On accept: if last, k=0 and go AR; else k++ and go WB_RD. Minimum 2 cycles per beat.
- AR: o_mem_arvalid=1, araddr = miss addr with OFS bits zeroed, held stable until i_mem_arready; then go FILL.
- FILL: each i_mem_rvalid raises o_fill_we the same cycle (combinational pass of rdata, word=beat counter); counter wraps at LINE_WORDS. On the LINE_WORDS-th beat go COMMIT. If i_mem_rlast disagrees with the final-beat condition, set o_err; the counter alone decides completion.
- COMMIT (1 cycle): o_tag_we=1, o_tag = miss tag, o_lru_update=1 with hitway = victim, o_done=1; next cycle IDLE.
- i_mem_rvalid outside FILL is ignored.
- i_killmask is sampled only in SELECT; changes later are ignored.
- Reset mid-miss: abort immediately with no further tag/LRU writes. Beats still in flight after reset are dropped.
- Latency with clean victim and zero-wait memory: miss accept to o_done = 3 + LINE_WORDS cycles + memory read latency.

Test Plan:
- Clean miss, set all invalid, addr 0x0000_1230: victim way0, no writes, araddr 0x0000_1230, 4 fill beats, o_tag_we, o_lru_hitway=0001, o_done once.
- Set full, killmask 0100, way2 dirty, tag 0x5: 4 write beats to tag 0x5 same index, words 0..3, wlast only on beat 3; then fill way2, hitway=0100.
- Writeback with i_mem_wready low 3 cycles per beat: wvalid/wdata/waddr stable until accept, no duplicated or dropped words.
- killmask 0000 with all ways valid and clean: victim way3; killmask 0110: victim way1.
- rlast on beat 2 of 4: o_err=1, fill still completes after beat 3, o_done pulses.
- i_rst asserted during FILL beat 1: next cycle IDLE, o_miss_ready=1, no o_tag_we/o_lru_update; later rvalid ignored.
